coin_acceptor: RTL and testbench
================================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEBOUNCE, default 4: consecutive stable cycles needed to accept a level change on a coin line (legal range 1..15).
REQ-002 Parameter DEPTH, default 4: coin FIFO depth in entries (power of two, 2..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 coin_raw  input  3  raw asynchronous, bouncy coin sensors; bit0 -> code 01, bit1 -> code 10, bit2 -> code 11.
REQ-006 ld  input  1  load strobe from the vending control FSM.
REQ-007 op  input  1  op select from the vending control FSM; 1 = add, 0 = subtract.
REQ-008 sel  output  2  coin code presented to the control FSM; 00 = no coin.
REQ-009 count  output  4  current FIFO occupancy, 0..DEPTH.
REQ-010 err  output  1  sticky flag; a coin was lost.

Function
REQ-011 Each coin_raw bit SHALL pass through a two-flop synchronizer (sync1, then sync2) before any other use.
REQ-012 Each channel SHALL keep a debounced level db and a counter cnt.
- cnt clears on any cycle where sync2 == db.
- cnt increments on any cycle where sync2 != db.
- db toggles and cnt clears at the edge where the DEBOUNCE-th consecutive mismatch is sampled.
REQ-013 A db transition 0->1 SHALL set that channel's pending bit at the same edge; 1->0 transitions SHALL have no effect.
REQ-014 A mismatch lasting fewer than DEBOUNCE cycles SHALL NOT change db and SHALL NOT produce a coin.
REQ-015 If a channel's pending bit is already set when a new 0->1 db transition occurs on that channel, the coin SHALL be dropped and err SHALL set.
REQ-016 Arbiter, evaluated each cycle:
- acts only if the FIFO is not full;
- pushes the code of the highest-priority pending channel (bit2 > bit1 > bit0);
- clears that pending bit at the same edge;
- pushes at most one entry per cycle.
REQ-017 While the FIFO is full, pending bits SHALL hold; no coin is lost unless REQ-015 applies.
REQ-018 sel SHALL equal the FIFO head code, registered, when count > 0, and 00 when count == 0.
REQ-019 Acknowledge is ack = ld AND op, sampled at the clock edge.
- With ack = 1 and count > 0, the head SHALL pop at that edge.
- ack = 1 with count == 0 SHALL be ignored.
- ld = 1 with op = 0 (a subtract/decrement cycle) SHALL NOT pop.
REQ-020 A push and a pop in the same cycle SHALL both occur; count stays unchanged and FIFO order is preserved.
REQ-021 sel SHALL remain stable from its first presentation until the edge after the pop, so the control FSM sees each code in exactly one WAIT cycle.
- Sequence: WAIT sees sel != 00 -> ADD cycle (ack) -> next code or 00 at the return to WAIT.
REQ-022 Latency, empty FIFO, no pending: a coin_raw bit rising and held from edge 0 SHALL give sel != 00 after edge DEBOUNCE+2 (after edge 6 at default).
REQ-023 FIFO read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor go below 0.
REQ-024 Presented codes SHALL never be 00; the FIFO SHALL hold only codes 01, 10 and 11.

Reset
REQ-025 When rst = 1 at an edge, SHALL clear: sync flops, db, cnt, pending bits, FIFO pointers, count, err; sel reads 00 from the following cycle.
REQ-026 Reset mid-operation SHALL discard all queued and pending coins, with no sel pulse afterward.
- A coin_raw bit held high through reset release counts as one new coin, accepted per REQ-012.
REQ-027 err SHALL clear only on reset.

Verification
REQ-028 Clean coin: DEBOUNCE=4, coin_raw=001 held from edge 0, ack tied 0 -> sel=01 after edge 6, count=1; it holds 01 indefinitely.
REQ-029 Glitch: coin_raw=010 for 3 cycles, then 000 -> sel stays 00, count=0, err=0.
REQ-030 Handshake:
- stimulus: queue codes 01 then 11; pulse ld=1, op=1 for one cycle;
- response: sel changes 01 -> 11 at that edge; a second pulse gives sel=00, count=0;
- also: ld=1, op=0 causes no pop.
REQ-031 Full FIFO:
- stimulus: queue 4 coins with ack held 0; raise a fifth coin on bit0;
- response: count=4 and bit0 stays pending;
- then one ack -> fifth coin pushed; count returns to 4, sel shows the second-queued code;
- then a second bit0 coin while still pending -> err=1.
REQ-032 Simultaneous edges: bits 0 and 2 debounce on the same cycle, empty FIFO -> FIFO order 11 then 01; a push on the same cycle as an ack keeps count constant.
REQ-033 Reset mid-queue: count=3, assert rst one cycle -> count=0, sel=00, err=0 next cycle, with no later sel pulse.

Source files
------------

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounced three-channel coin acceptor with code FIFO and sticky loss flag
module coin_acceptor #(
    parameter int DEBOUNCE = 4,
    parameter int DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] coin_raw,
    input  logic       ld,
    input  logic       op,
    output logic [1:0] sel,
    output logic [3:0] count,
    output logic       err
);

    localparam int       AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    // synchronizer flops
    logic [2:0]    sync1_q;
    logic [2:0]    sync2_q;

    // per-channel debounce state
    logic [2:0]    db_q;
    logic [2:0]    db_d;
    logic [3:0]    cnt_q [3];
    logic [3:0]    cnt_d [3];
    logic [2:0]    rise;

    // coins seen but not yet queued, plus the loss flag
    logic [2:0]    pending_q;
    logic [2:0]    pending_d;
    logic          err_q;
    logic          err_d;

    // arbiter results
    logic [2:0]    grant;
    logic [1:0]    push_code;
    logic          push;
    logic          pop;

    // code FIFO
    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_next;
    logic [3:0]    count_q;
    logic [3:0]    count_d;
    logic [1:0]    sel_q;
    logic [1:0]    sel_d;

    // two-flop synchronizer on every raw coin line
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= coin_raw;
            sync2_q <= sync1_q;
        end
    end

    // debounce: db flips on the DEBOUNCE-th consecutive mismatch; only a rising flip is a coin
    always_comb begin
        db_d = db_q;
        rise = '0;
        cnt_d = '{default: '0};
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i] = ~db_q[i];
                    rise[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // debounce state register
    always_ff @(posedge clk) begin
        if (rst) begin
            db_q  <= '0;
            cnt_q <= '{default: '0};
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    // priority arbiter: highest pending channel goes into the FIFO when there is room
    always_comb begin
        grant     = '0;
        push_code = 2'b00;
        if (count_q != DEPTH_C) begin
            if (pending_q[2]) begin
                grant     = 3'b100;
                push_code = 2'b11;
            end else if (pending_q[1]) begin
                grant     = 3'b010;
                push_code = 2'b10;
            end else if (pending_q[0]) begin
                grant     = 3'b001;
                push_code = 2'b01;
            end
        end
        push = |grant;
    end

    // pending bookkeeping; a new coin on a channel whose earlier coin is still waiting is lost
    always_comb begin
        pending_d = pending_q & ~grant;
        err_d     = err_q;
        for (int i = 0; i < 3; i++) begin
            if (rise[i]) begin
                if (pending_q[i] && !grant[i]) begin
                    err_d = 1'b1;
                end
                pending_d[i] = 1'b1;
            end
        end
    end

    // pending and error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    // pop control and next head: sel is registered from the post-edge FIFO head
    always_comb begin
        pop     = ld && op && (count_q != 4'd0);
        rd_next = rd_ptr_q + AW'(1);
        count_d = count_q + {3'b000, push} - {3'b000, pop};
        sel_d   = 2'b00;
        if (pop) begin
            if (count_q > 4'd1) begin
                sel_d = mem_q[rd_next];
            end else if (push) begin
                sel_d = push_code;
            end
        end else if (count_q != 4'd0) begin
            sel_d = mem_q[rd_ptr_q];
        end else if (push) begin
            sel_d = push_code;
        end
    end

    // FIFO storage; contents are qualified by count so they need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_code;
        end
    end

    // FIFO pointers, occupancy and presented code
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sel_q    <= 2'b00;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_next;
            end
            count_q <= count_d;
            sel_q   <= sel_d;
        end
    end

    assign sel   = sel_q;
    assign count = count_q;
    assign err   = err_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - directed scoreboard bench for coin_acceptor
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] coin_raw = 3'b000;
    logic       ld = 1'b0;
    logic       op = 1'b0;
    logic [1:0] sel;
    logic [3:0] count;
    logic       err;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q [$];

    coin_acceptor #(.DEBOUNCE(4), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .coin_raw (coin_raw),
        .ld       (ld),
        .op       (op),
        .sel      (sel),
        .count    (count),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic coin(input int b, input logic [1:0] code, input bit expect_push);
        coin_raw[b] = 1'b1;
        step(8);
        coin_raw[b] = 1'b0;
        step(8);
        if (expect_push) exp_q.push_back(code);
    endtask

    task automatic ack(input string tag);
        logic [1:0] head;
        head = (exp_q.size() > 0) ? exp_q[0] : 2'b00;
        chk({tag, "_head"}, {2'b00, sel}, {2'b00, head});
        ld = 1'b1;
        op = 1'b1;
        step(1);
        ld = 1'b0;
        op = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        step(1);
        head = (exp_q.size() > 0) ? exp_q[0] : 2'b00;
        chk({tag, "_next"}, {2'b00, sel}, {2'b00, head});
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
        chk("rst_sel", {2'b00, sel}, 4'h0);
        chk("rst_count", count, 4'h0);
        chk("rst_err", {3'b000, err}, 4'h0);

        // clean coin latency: nothing after edge 5, code 01 after edge 6
        coin_raw[0] = 1'b1;
        step(6);
        chk("lat_before", {2'b00, sel}, 4'h0);
        step(1);
        exp_q.push_back(2'b01);
        chk("lat_sel", {2'b00, sel}, 4'h1);
        chk("lat_count", count, 4'h1);
        step(20);
        chk("clean_hold", {2'b00, sel}, 4'h1);
        coin_raw[0] = 1'b0;
        step(8);
        ack("clean_ack");
        chk("clean_empty", count, 4'h0);

        // glitch shorter than the debounce window
        coin_raw[1] = 1'b1;
        step(3);
        coin_raw[1] = 1'b0;
        step(12);
        chk("glitch_sel", {2'b00, sel}, 4'h0);
        chk("glitch_count", count, 4'h0);
        chk("glitch_err", {3'b000, err}, 4'h0);

        // handshake: subtract cycle does not pop, add cycles pop in order
        coin(0, 2'b01, 1'b1);
        coin(2, 2'b11, 1'b1);
        chk("hs_count", count, 4'h2);
        ld = 1'b1;
        op = 1'b0;
        step(1);
        ld = 1'b0;
        step(1);
        chk("hs_sub_sel", {2'b00, sel}, 4'h1);
        chk("hs_sub_count", count, 4'h2);
        ack("hs_ack1");
        ack("hs_ack2");
        chk("hs_empty", count, 4'h0);

        // full FIFO: fifth coin waits pending, a second one on that channel is lost
        coin(0, 2'b01, 1'b1);
        coin(1, 2'b10, 1'b1);
        coin(2, 2'b11, 1'b1);
        coin(0, 2'b01, 1'b1);
        coin(0, 2'b01, 1'b1);
        chk("full_count", count, 4'h4);
        chk("full_err0", {3'b000, err}, 4'h0);
        coin(0, 2'b01, 1'b0);
        chk("full_err1", {3'b000, err}, 4'h1);
        ack("full_ack");
        chk("full_refill", count, 4'h4);
        ack("drain1");
        ack("drain2");
        ack("drain3");
        ack("drain4");
        chk("drain_count", count, 4'h0);
        chk("err_sticky", {3'b000, err}, 4'h1);

        // simultaneous debounce on bits 0 and 2: 11 queued before 01
        coin_raw = 3'b101;
        step(8);
        coin_raw = 3'b000;
        step(8);
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b01);
        chk("simul_count", count, 4'h2);
        chk("simul_sel", {2'b00, sel}, 4'h3);

        // push lands on the same edge as the ack
        coin_raw[1] = 1'b1;
        step(6);
        chk("pp_head", {2'b00, sel}, 4'h3);
        ld = 1'b1;
        op = 1'b1;
        step(1);
        ld = 1'b0;
        op = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(2'b10);
        chk("pp_count", count, 4'h2);
        chk("pp_sel", {2'b00, sel}, 4'h1);
        step(4);
        coin_raw[1] = 1'b0;
        step(8);
        ack("pp_ack1");
        ack("pp_ack2");
        chk("pp_empty", count, 4'h0);

        // reset with three coins queued
        coin(0, 2'b01, 1'b1);
        coin(1, 2'b10, 1'b1);
        coin(2, 2'b11, 1'b1);
        chk("mid_count", count, 4'h3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        exp_q.delete();
        chk("mid_rst_count", count, 4'h0);
        chk("mid_rst_sel", {2'b00, sel}, 4'h0);
        chk("mid_rst_err", {3'b000, err}, 4'h0);
        step(20);
        chk("mid_quiet_sel", {2'b00, sel}, 4'h0);
        chk("mid_quiet_count", count, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
